// File: rtl/cop_regfile_pkg.sv
// Shared coprocessor definitions: default operand geometry and the zeroize
// engine state encoding.
package cop_regfile_pkg;

  localparam int COP_DATA_WIDTH     = 128;
  localparam int COP_REG_DEPTH      = 16;
  localparam int COP_REG_ADDR_WIDTH = 4;
  localparam int COP_NUM_READ       = 3;

  typedef enum logic [1:0] {
    ZS_IDLE = 2'd0,
    ZS_WIPE = 2'd1,
    ZS_DONE = 2'd2
  } zeroize_state_t;

endpackage

// File: rtl/cop_regfile_rdport.sv
// One combinational read port: register select, zero-register forcing,
// byte-merge write bypass and masking while a wipe is in progress.
module cop_regfile_rdport
  import cop_regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = COP_DATA_WIDTH,
  parameter int REG_DEPTH      = COP_REG_DEPTH,
  parameter int REG_ADDR_WIDTH = COP_REG_ADDR_WIDTH,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [REG_DEPTH-1:0]                 busy,
  input  logic [REG_ADDR_WIDTH-1:0]            rd_addr,
  input  logic                                 wr_en,
  input  logic [REG_ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [DATA_WIDTH-1:0]                wr_mask,
  input  logic                                 wipe_active,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_busy
);

  logic [DATA_WIDTH-1:0] stored;
  logic                  busy_bit;
  logic                  in_range;
  logic                  is_zero;
  logic                  hit;

  always_comb begin
    stored   = '0;
    busy_bit = 1'b0;
    in_range = 1'b0;
    for (int r = 0; r < REG_DEPTH; r++) begin
      if (rd_addr == REG_ADDR_WIDTH'(r)) begin
        stored   = regs[r];
        busy_bit = busy[r];
        in_range = 1'b1;
      end
    end
    is_zero = (ZERO_REG != 0) && (rd_addr == '0);
    hit     = (BYPASS != 0) && wr_en && in_range && (rd_addr == wr_addr);
    rd_data = '0;
    // Key material must never be visible while it is being wiped.
    if (!wipe_active && !is_zero) begin
      rd_data = hit ? ((stored & ~wr_mask) | (wr_data & wr_mask)) : stored;
    end
    rd_busy = busy_bit && !is_zero;
  end

endmodule

// File: rtl/cop_regfile.sv
// Coprocessor key/state register file: byte-lane writes, NUM_READ read ports,
// per-register busy scoreboard and a sequential zeroization engine.
module cop_regfile
  import cop_regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = COP_DATA_WIDTH,
  parameter int REG_DEPTH      = COP_REG_DEPTH,
  parameter int REG_ADDR_WIDTH = COP_REG_ADDR_WIDTH,
  parameter int NUM_READ       = COP_NUM_READ,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [REG_ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [DATA_WIDTH/8-1:0]            wr_be,
  input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_READ-1:0]                rd_busy,
  input  logic                               busy_set,
  input  logic [REG_ADDR_WIDTH-1:0]          busy_addr,
  input  logic                               zeroize_req,
  output logic                               zeroize_busy,
  output logic                               zeroize_done
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [REG_ADDR_WIDTH-1:0] LAST_REG = REG_ADDR_WIDTH'(REG_DEPTH - 1);

  logic [REG_DEPTH-1:0][DATA_WIDTH-1:0] regs_reg;
  logic [REG_DEPTH-1:0]                 busy_reg;
  zeroize_state_t                       state_reg;
  logic [REG_ADDR_WIDTH-1:0]            wipe_cnt_reg;
  logic                                 zeroize_busy_reg;
  logic                                 zeroize_done_reg;

  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_ok;
  logic                  set_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_mask
      assign wr_mask[gi*8 +: 8] = {8{wr_be[gi]}};
    end
  endgenerate

  // zeroize_busy_reg is high exactly when the engine is outside IDLE.
  assign wr_ok  = we && !zeroize_busy_reg;
  assign set_ok = busy_set && !zeroize_busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_reg <= '0;
      busy_reg <= '0;
    end else begin
      for (int r = 0; r < REG_DEPTH; r++) begin
        if (state_reg == ZS_WIPE) begin
          if (wipe_cnt_reg == REG_ADDR_WIDTH'(r)) begin
            regs_reg[r] <= '0;
          end
        end else if (wr_ok && (wr_addr == REG_ADDR_WIDTH'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
          regs_reg[r] <= (regs_reg[r] & ~wr_mask) | (wr_data & wr_mask);
        end
        // A fresh busy_set outranks the clear from a same-cycle write.
        if (state_reg == ZS_DONE) begin
          busy_reg[r] <= 1'b0;
        end else if (set_ok && (busy_addr == REG_ADDR_WIDTH'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
          busy_reg[r] <= 1'b1;
        end else if (wr_ok && (wr_addr == REG_ADDR_WIDTH'(r))) begin
          busy_reg[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ZS_IDLE;
      wipe_cnt_reg     <= '0;
      zeroize_busy_reg <= 1'b0;
      zeroize_done_reg <= 1'b0;
    end else begin
      zeroize_done_reg <= 1'b0;
      case (state_reg)
        ZS_IDLE: begin
          if (zeroize_req) begin
            state_reg        <= ZS_WIPE;
            wipe_cnt_reg     <= '0;
            zeroize_busy_reg <= 1'b1;
          end
        end
        ZS_WIPE: begin
          if (wipe_cnt_reg == LAST_REG) begin
            state_reg        <= ZS_DONE;
            zeroize_done_reg <= 1'b1;
          end else begin
            wipe_cnt_reg <= wipe_cnt_reg + 1'b1;
          end
        end
        ZS_DONE: begin
          state_reg        <= ZS_IDLE;
          wipe_cnt_reg     <= '0;
          zeroize_busy_reg <= 1'b0;
        end
        default: begin
          state_reg        <= ZS_IDLE;
          wipe_cnt_reg     <= '0;
          zeroize_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign zeroize_busy = zeroize_busy_reg;
  assign zeroize_done = zeroize_done_reg;

  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rdport
      cop_regfile_rdport #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_DEPTH     (REG_DEPTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .ZERO_REG      (ZERO_REG),
        .BYPASS        (BYPASS)
      ) u_rdport (
        .regs       (regs_reg),
        .busy       (busy_reg),
        .rd_addr    (rd_addr[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
        .wr_en      (wr_ok),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .wipe_active(zeroize_busy_reg),
        .rd_data    (rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .rd_busy    (rd_busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_cop_regfile.sv
// Bench for cop_regfile: directed vector table, scoreboard and zeroize
// sequences, then random traffic against an array-based reference model.
module tb_cop_regfile;
  import cop_regfile_pkg::*;

  localparam int DW = 128;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int DEPTH = 16;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NR-1:0] rd_busy, rd_busy_nb;
  logic busy_set;
  logic [AW-1:0] busy_addr;
  logic zeroize_req;
  logic zeroize_busy, zeroize_done, zeroize_busy_nb, zeroize_done_nb;

  always #5 clk = ~clk;

  cop_regfile #(.DATA_WIDTH(DW), .REG_DEPTH(DEPTH), .REG_ADDR_WIDTH(AW), .NUM_READ(NR),
                .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .busy_set(busy_set),
    .busy_addr(busy_addr), .zeroize_req(zeroize_req), .zeroize_busy(zeroize_busy),
    .zeroize_done(zeroize_done));

  cop_regfile #(.DATA_WIDTH(DW), .REG_DEPTH(DEPTH), .REG_ADDR_WIDTH(AW), .NUM_READ(NR),
                .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb), .busy_set(busy_set),
    .busy_addr(busy_addr), .zeroize_req(zeroize_req), .zeroize_busy(zeroize_busy_nb),
    .zeroize_done(zeroize_done_nb));

  int n_pass = 0;
  int n_total = 0;
  logic [DW-1:0] model_regs [DEPTH];
  logic          model_busy [DEPTH];

  typedef struct {
    logic          w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [NB-1:0] be;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_old;
    logic [DW-1:0] exp_same;
    logic [DW-1:0] exp_next;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [DW-1:0] port(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] port_nb(input int k);
    return rd_data_nb[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] v;
    v = old;
    for (int i = 0; i < NB; i++) if (be[i]) v[i*8 +: 8] = d[i*8 +: 8];
    return v;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic byp);
    logic [DW-1:0] v;
    if (a == '0) return '0;
    v = model_regs[a];
    if (byp && we && (wr_addr == a)) v = merge(v, wr_data, wr_be);
    return v;
  endfunction

  task automatic model_commit();
    if (we && (wr_addr != '0)) model_regs[wr_addr] = merge(model_regs[wr_addr], wr_data, wr_be);
    if (we) model_busy[wr_addr] = 1'b0;
    if (busy_set && (busy_addr != '0)) model_busy[busy_addr] = 1'b1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < DEPTH; r++) begin
      model_regs[r] = '0;
      model_busy[r] = 1'b0;
    end
  endtask

  task automatic idle();
    we = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    busy_set = 1'b0; busy_addr = '0; zeroize_req = 1'b0;
  endtask

  task automatic set_rd_all(input logic [AW-1:0] a);
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    model_commit();
    cyc();
  endtask

  initial begin
    vec_t vt [7];
    logic [DW-1:0] kdat, a_all, f_all, aa55, xdat, dex;
    int pulses;
    logic [AW-1:0] a;

    kdat  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    a_all = {16{8'hAA}};
    f_all = {16{8'h55}};
    aa55  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_55555555;
    xdat  = 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE;
    dex   = 128'hDE000000_00000000_00000000_000000FE;
    vt[0] = '{1'b1, 4'd3, kdat, 16'hFFFF, 4'd3, '0, kdat, kdat};
    vt[1] = '{1'b1, 4'd0, kdat, 16'hFFFF, 4'd0, '0, '0, '0};
    vt[2] = '{1'b1, 4'd5, a_all, 16'hFFFF, 4'd5, '0, a_all, a_all};
    vt[3] = '{1'b1, 4'd5, f_all, 16'h000F, 4'd5, a_all, aa55, aa55};
    vt[4] = '{1'b1, 4'd5, {16{8'h11}}, 16'h0000, 4'd5, aa55, aa55, aa55};
    vt[5] = '{1'b0, 4'd3, {DW{1'b1}}, 16'hFFFF, 4'd3, kdat, kdat, kdat};
    vt[6] = '{1'b1, 4'd9, xdat, 16'h8001, 4'd9, '0, dex, dex};

    // Reset state
    rst = 1'b1;
    idle();
    rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    set_rd_all(4'd3);
    #1;
    for (int k = 0; k < NR; k++) chk($sformatf("reset_rd_data_p%0d", k), port(k), '0);
    chk("reset_rd_busy", DW'(rd_busy), '0);
    chk1("reset_zeroize_busy", zeroize_busy, 1'b0);
    chk1("reset_zeroize_done", zeroize_done, 1'b0);
    $display("reset: rd_busy=%b zbusy=%b zdone=%b", rd_busy, zeroize_busy, zeroize_done);
    rst = 1'b0;
    cyc();

    // Directed write/bypass vectors
    for (int i = 0; i < 7; i++) begin
      we = vt[i].w; wr_addr = vt[i].wa; wr_data = vt[i].wd; wr_be = vt[i].be;
      set_rd_all(vt[i].ra);
      #1;
      for (int k = 0; k < NR; k++) chk($sformatf("vec%0d_same_p%0d", i, k), port(k), vt[i].exp_same);
      chk($sformatf("vec%0d_nobypass_same", i), port_nb(1), vt[i].exp_old);
      $display("vec %0d: we=%b wa=%0d be=%h ra=%0d rd=%h", i, we, wr_addr, wr_be, vt[i].ra, port(0));
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_next", i), port(2), vt[i].exp_next);
      chk($sformatf("vec%0d_nobypass_next", i), port_nb(0), vt[i].exp_next);
    end

    // Scoreboard
    set_rd_all(4'd7);
    busy_set = 1'b1; busy_addr = 4'd7;
    #1;
    chk1("sb_set_same_cycle", rd_busy[1], 1'b0);
    tick(); idle(); #1;
    chk1("sb_set_next", rd_busy[1], 1'b1);
    $display("sb: set r7 rd_busy=%b", rd_busy);
    we = 1'b1; wr_addr = 4'd7; wr_be = '0;
    #1;
    chk1("sb_clear_same_cycle", rd_busy[1], 1'b1);
    tick(); idle(); #1;
    chk1("sb_clear_next", rd_busy[1], 1'b0);
    $display("sb: write r7 rd_busy=%b", rd_busy);
    busy_set = 1'b1; busy_addr = 4'd7; we = 1'b1; wr_addr = 4'd7; wr_be = '1; wr_data = xdat;
    tick(); idle(); #1;
    chk1("sb_set_wins", rd_busy[0], 1'b1);
    $display("sb: set+write r7 rd_busy=%b", rd_busy);
    busy_set = 1'b1; busy_addr = 4'd0;
    tick(); idle(); set_rd_all(4'd0); #1;
    chk("sb_r0_never_busy", DW'(rd_busy), '0);

    // Random traffic against the model
    for (int t = 0; t < 150; t++) begin
      we = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: wr_be = '1;
        1: wr_be = '0;
        default: wr_be = NB'($urandom());
      endcase
      busy_set = ($urandom_range(0, 3) == 0);
      busy_addr = AW'($urandom_range(0, DEPTH - 1));
      for (int k = 0; k < NR; k++)
        rd_addr[k*AW +: AW] = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
      #1;
      for (int k = 0; k < NR; k++) begin
        a = rd_addr[k*AW +: AW];
        chk($sformatf("rnd%0d_data_p%0d", t, k), port(k), model_read(a, 1'b1));
        chk1($sformatf("rnd%0d_busy_p%0d", t, k), rd_busy[k], (a != '0) && model_busy[a]);
      end
      chk($sformatf("rnd%0d_nobypass_p0", t), port_nb(0), model_read(rd_addr[AW-1:0], 1'b0));
      $display("rnd %0d: we=%b wa=%0d be=%h bs=%b ba=%0d ra=%h rd0=%h", t, we, wr_addr, wr_be,
               busy_set, busy_addr, rd_addr, port(0));
      tick();
    end
    idle();

    // Zeroize: fill, wipe, confirm blocking and masking, then all clear
    for (int r = 1; r < DEPTH; r++) begin
      we = 1'b1; wr_addr = AW'(r); wr_data = {4{32'hC0DE0000 + r}}; wr_be = '1;
      tick();
    end
    idle(); busy_set = 1'b1; busy_addr = 4'd4;
    tick(); idle();
    set_rd_all(4'd15);
    #1;
    chk("pre_wipe_r15", port(0), {4{32'hC0DE000F}});
    zeroize_req = 1'b1;
    #1;
    chk1("zreq_cycle_busy_low", zeroize_busy, 1'b0);
    cyc();
    zeroize_req = 1'b0;
    pulses = 0;
    for (int c = 1; c <= DEPTH; c++) begin
      we = 1'b1; wr_addr = 4'd2; wr_data = '1; wr_be = '1; busy_set = 1'b1; busy_addr = 4'd8;
      rd_addr[AW +: AW] = 4'd2;
      #1;
      chk1($sformatf("wipe_c%0d_busy", c), zeroize_busy, 1'b1);
      if (zeroize_done) pulses++;
      chk($sformatf("wipe_c%0d_masked_p0", c), port(0), '0);
      chk($sformatf("wipe_c%0d_masked_p1", c), port(1), '0);
      $display("wipe cycle %0d: zbusy=%b zdone=%b rd0=%h", c, zeroize_busy, zeroize_done, port(0));
      cyc();
    end
    idle();
    #1;
    chk1("wipe_no_early_done", pulses == 0, 1'b1);
    chk1("wipe_done_at_17", zeroize_done, 1'b1);
    chk1("wipe_done_busy", zeroize_busy, 1'b1);
    cyc();
    chk1("after_done_pulse_low", zeroize_done, 1'b0);
    chk1("after_done_busy_low", zeroize_busy, 1'b0);
    model_clear();
    for (int r = 0; r < DEPTH; r++) begin
      set_rd_all(AW'(r));
      #1;
      chk($sformatf("post_wipe_r%0d", r), port(0), '0);
      chk1($sformatf("post_wipe_busy_r%0d", r), rd_busy[0], 1'b0);
    end

    // Reset in the middle of a wipe
    we = 1'b1; wr_addr = 4'd12; wr_data = xdat; wr_be = '1;
    tick(); idle();
    zeroize_req = 1'b1;
    cyc();
    zeroize_req = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    set_rd_all(4'd12);
    #1;
    chk1("rst_mid_wipe_busy", zeroize_busy, 1'b0);
    chk1("rst_mid_wipe_done", zeroize_done, 1'b0);
    cyc();
    rst = 1'b0;
    model_clear();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (zeroize_done || zeroize_busy) pulses++;
      cyc();
    end
    chk1("rst_no_done_pulse", pulses == 0, 1'b1);
    chk("rst_cleared_r12", port(0), '0);
    $display("rst mid-wipe: zbusy=%b zdone=%b r12=%h", zeroize_busy, zeroize_done, port(0));
    zeroize_req = 1'b1;
    cyc();
    zeroize_req = 1'b0;
    pulses = 0;
    for (int c = 1; c <= DEPTH; c++) begin
      if (zeroize_done) pulses++;
      cyc();
    end
    chk1("rewipe_no_early_done", pulses == 0, 1'b1);
    chk1("rewipe_done_at_17", zeroize_done, 1'b1);
    cyc();

    // Request held high across WIPE and DONE
    zeroize_req = 1'b1;
    cyc();
    pulses = 0;
    for (int c = 1; c <= DEPTH; c++) begin
      if (zeroize_done || !zeroize_busy) pulses++;
      cyc();
    end
    chk1("held_no_restart", pulses == 0, 1'b1);
    chk1("held_first_done", zeroize_done, 1'b1);
    cyc();
    chk1("held_idle_gap", zeroize_busy, 1'b0);
    cyc();
    chk1("held_second_start", zeroize_busy, 1'b1);
    zeroize_req = 1'b0;
    pulses = 0;
    for (int c = 19; c <= 34; c++) begin
      if (zeroize_done) pulses++;
      cyc();
    end
    chk1("held_second_no_early", pulses == 0, 1'b1);
    chk1("held_second_done", zeroize_done, 1'b1);
    $display("held req: second done at cycle 35 zdone=%b", zeroize_done);
    cyc();
    chk1("held_end_done_low", zeroize_done, 1'b0);
    chk1("held_end_busy_low", zeroize_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
